// File: rtl/ama_riscv_alu_pkg.sv
// Shared ALU definitions: op_sel encodings, default datapath width and legality check.
package ama_riscv_alu_pkg;

  localparam int ALU_DATA_W = 32;

  typedef enum logic [3:0] {
    ALU_ADD    = 4'b0000,
    ALU_SUB    = 4'b1000,
    ALU_SLL    = 4'b0001,
    ALU_SRL    = 4'b0101,
    ALU_SRA    = 4'b1101,
    ALU_SLT    = 4'b0010,
    ALU_SLTU   = 4'b0011,
    ALU_XOR    = 4'b0100,
    ALU_OR     = 4'b0110,
    ALU_AND    = 4'b0111,
    ALU_PASS_B = 4'b1111
  } alu_op_e;

  function automatic logic alu_op_legal(input logic [3:0] op);
    case (op)
      ALU_ADD, ALU_SUB, ALU_SLL, ALU_SRL, ALU_SRA, ALU_SLT,
      ALU_SLTU, ALU_XOR, ALU_OR, ALU_AND, ALU_PASS_B: alu_op_legal = 1'b1;
      default:                                        alu_op_legal = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/ama_riscv_alu.sv
// Combinational RISC-V integer ALU; unknown encodings produce 0 and raise illegal.
module ama_riscv_alu
  import ama_riscv_alu_pkg::*;
#(
  parameter int DATA_W = ALU_DATA_W
) (
  input  logic [3:0]        op_sel,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] result,
  output logic              illegal
);

  logic [4:0] shamt;

  assign shamt   = b[4:0];
  assign illegal = ~alu_op_legal(op_sel);

  always_comb begin
    result = '0;
    case (op_sel)
      ALU_ADD:    result = a + b;
      ALU_SUB:    result = a - b;
      ALU_SLL:    result = a << shamt;
      ALU_SRL:    result = a >> shamt;
      ALU_SRA:    result = $unsigned($signed(a) >>> shamt);
      ALU_SLT:    result = {{(DATA_W-1){1'b0}}, ($signed(a) < $signed(b))};
      ALU_SLTU:   result = {{(DATA_W-1){1'b0}}, (a < b)};
      ALU_XOR:    result = a ^ b;
      ALU_OR:     result = a | b;
      ALU_AND:    result = a & b;
      ALU_PASS_B: result = b;
      default:    result = '0;
    endcase
  end

endmodule

// File: rtl/ama_riscv_alu_arbiter.sv
// Two-port arbiter sharing one ALU with a single tagged result register.
// ALU_ARB_ROUND_ROBIN_EN selects round-robin arbitration; otherwise port 0 has fixed priority.
module ama_riscv_alu_arbiter
  import ama_riscv_alu_pkg::*;
#(
  parameter int DATA_W = ALU_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [3:0]        req0_op,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [3:0]        req1_op,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  output logic              rsp0_valid,
  input  logic              rsp0_ready,
  output logic              rsp1_valid,
  input  logic              rsp1_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_err
);

  logic              out_valid;
  logic              out_id;
  logic              out_err;
  logic [DATA_W-1:0] out_data;

  logic              out_accept;
  logic              slot_free;
  logic              grant;
  logic              accept;

  logic [3:0]        alu_op;
  logic [DATA_W-1:0] alu_a;
  logic [DATA_W-1:0] alu_b;
  logic [DATA_W-1:0] alu_result;
  logic              alu_illegal;

  assign rsp0_valid = out_valid & ~out_id;
  assign rsp1_valid = out_valid & out_id;
  assign rsp_data   = out_data;
  assign rsp_err    = out_err;

  assign out_accept = (rsp0_valid & rsp0_ready) | (rsp1_valid & rsp1_ready);
  assign slot_free  = ~out_valid | out_accept;

`ifdef ALU_ARB_ROUND_ROBIN_EN
  logic rr_last;

  // On a tie the port that did not win last time gets the ALU.
  always_comb begin
    grant = 1'b0;
    if (req0_valid && req1_valid) begin
      grant = ~rr_last;
    end else if (req1_valid) begin
      grant = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_last <= 1'b1;
    end else if (accept) begin
      rr_last <= grant;
    end
  end
`else
  assign grant = ~req0_valid & req1_valid;
`endif

  assign accept     = (req0_valid | req1_valid) & slot_free;
  assign req0_ready = slot_free & req0_valid & ~grant;
  assign req1_ready = slot_free & req1_valid & grant;

  assign alu_op = grant ? req1_op : req0_op;
  assign alu_a  = grant ? req1_a  : req0_a;
  assign alu_b  = grant ? req1_b  : req0_b;

  ama_riscv_alu #(
    .DATA_W (DATA_W)
  ) u_alu (
    .op_sel  (alu_op),
    .a       (alu_a),
    .b       (alu_b),
    .result  (alu_result),
    .illegal (alu_illegal)
  );

  // A new capture takes precedence over draining, so the slot can turn over every cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_id    <= 1'b0;
      out_data  <= '0;
      out_err   <= 1'b0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_id    <= grant;
      out_data  <= alu_result;
      out_err   <= alu_illegal;
    end else if (out_accept) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ama_riscv_alu_arbiter.sv
// Self-checking bench for ama_riscv_alu_arbiter: directed scenarios plus a randomized scoreboard run.
module tb_ama_riscv_alu_arbiter;

  localparam int DATA_W = 32;

`ifdef ALU_ARB_ROUND_ROBIN_EN
  localparam bit RR_EN = 1'b1;
`else
  localparam bit RR_EN = 1'b0;
`endif

  localparam logic [3:0] OP_ADD    = 4'b0000;
  localparam logic [3:0] OP_SUB    = 4'b1000;
  localparam logic [3:0] OP_SLL    = 4'b0001;
  localparam logic [3:0] OP_SRL    = 4'b0101;
  localparam logic [3:0] OP_SRA    = 4'b1101;
  localparam logic [3:0] OP_SLT    = 4'b0010;
  localparam logic [3:0] OP_SLTU   = 4'b0011;
  localparam logic [3:0] OP_XOR    = 4'b0100;
  localparam logic [3:0] OP_OR     = 4'b0110;
  localparam logic [3:0] OP_AND    = 4'b0111;
  localparam logic [3:0] OP_PASS_B = 4'b1111;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              req0_valid, req1_valid;
  logic              req0_ready, req1_ready;
  logic [3:0]        req0_op, req1_op;
  logic [DATA_W-1:0] req0_a, req0_b, req1_a, req1_b;
  logic              rsp0_valid, rsp1_valid;
  logic              rsp0_ready, rsp1_ready;
  logic [DATA_W-1:0] rsp_data;
  logic              rsp_err;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  ama_riscv_alu_arbiter #(.DATA_W(DATA_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_op    (req0_op),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_op    (req1_op),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .rsp0_valid (rsp0_valid),
    .rsp0_ready (rsp0_ready),
    .rsp1_valid (rsp1_valid),
    .rsp1_ready (rsp1_ready),
    .rsp_data   (rsp_data),
    .rsp_err    (rsp_err)
  );

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    n_checks++;
    if (observed !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic v0, input logic [3:0] op0, input logic [31:0] a0, input logic [31:0] b0,
                               input logic v1, input logic [3:0] op1, input logic [31:0] a1, input logic [31:0] b1,
                               input logic r0, input logic r1);
    req0_valid = v0; req0_op = op0; req0_a = a0; req0_b = b0;
    req1_valid = v1; req1_op = op1; req1_a = a1; req1_b = b1;
    rsp0_ready = r0; rsp1_ready = r1;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    applyStimulus(0, OP_ADD, 0, 0, 0, OP_ADD, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    nextCycle();
  endtask

  // Reference result {err, data} taken straight from the op table.
  function automatic logic [32:0] aluRef(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    logic signed [31:0] sa;
    int unsigned sh;
    sa = a;
    sh = b % 32;
    case (op)
      OP_ADD:    return {1'b0, a + b};
      OP_SUB:    return {1'b0, a - b};
      OP_SLL:    return {1'b0, a << sh};
      OP_SRL:    return {1'b0, a >> sh};
      OP_SRA:    return {1'b0, 32'(sa >>> sh)};
      OP_SLT:    return {1'b0, 32'($signed(a) < $signed(b))};
      OP_SLTU:   return {1'b0, 32'(a < b)};
      OP_XOR:    return {1'b0, a ^ b};
      OP_OR:     return {1'b0, a | b};
      OP_AND:    return {1'b0, a & b};
      OP_PASS_B: return {1'b0, b};
      default:   return {1'b1, 32'h0};
    endcase
  endfunction

  function automatic logic [3:0] randOp();
    logic [3:0] legal_ops [11];
    legal_ops = '{OP_ADD, OP_SUB, OP_SLL, OP_SRL, OP_SRA, OP_SLT, OP_SLTU, OP_XOR, OP_OR, OP_AND, OP_PASS_B};
    if ($urandom_range(0, 99) < 85) return legal_ops[$urandom_range(0, 10)];
    return 4'($urandom_range(0, 15));
  endfunction

  task automatic runRandom();
    int generated = 0;
    int accepted = 0;
    int cycles = 0;
    bit pend0 = 0, pend1 = 0, held = 0, held_port = 0, last = 1;
    bit r0, r1, out_acc, free, win, exp_r0, exp_r1;
    logic [3:0] op0 = 0, op1 = 0;
    logic [31:0] a0 = 0, b0 = 0, a1 = 0, b1 = 0;
    logic [32:0] q0[$];
    logic [32:0] q1[$];
    logic [32:0] front;
    while (cycles < 20000) begin
      if (generated >= 1000 && !pend0 && !pend1 && !held) break;
      if (!pend0 && generated < 1000 && $urandom_range(0, 99) < 60) begin
        pend0 = 1; generated++; op0 = randOp(); a0 = $urandom; b0 = $urandom;
      end
      if (!pend1 && generated < 1000 && $urandom_range(0, 99) < 60) begin
        pend1 = 1; generated++; op1 = randOp(); a1 = $urandom; b1 = $urandom;
      end
      r0 = ($urandom_range(0, 99) < 70);
      r1 = ($urandom_range(0, 99) < 70);
      applyStimulus(pend0, op0, a0, b0, pend1, op1, a1, b1, r0, r1);
      @(negedge clk);
      out_acc = held && (held_port ? r1 : r0);
      free    = !held || out_acc;
      win     = (pend0 && pend1) ? (RR_EN ? !last : 1'b0) : !pend0;
      exp_r0  = free && pend0 && !win;
      exp_r1  = free && pend1 && win;
      checkOutput("rand_req0_ready", req0_ready, exp_r0);
      checkOutput("rand_req1_ready", req1_ready, exp_r1);
      checkOutput("rand_rsp0_valid", rsp0_valid, held && !held_port);
      checkOutput("rand_rsp1_valid", rsp1_valid, held && held_port);
      if (held) begin
        checkOutput("rand_queue_nonempty", held_port ? q1.size() : q0.size(), 1);
        front = held_port ? (q1.size() > 0 ? q1[0] : 33'h0) : (q0.size() > 0 ? q0[0] : 33'h0);
        checkOutput("rand_rsp_data", rsp_data, front[31:0]);
        checkOutput("rand_rsp_err", rsp_err, front[32]);
      end
      if (out_acc) begin
        if (held_port) begin
          if (q1.size() > 0) void'(q1.pop_front());
        end else begin
          if (q0.size() > 0) void'(q0.pop_front());
        end
        held = 0;
      end
      if (free && (pend0 || pend1)) begin
        held = 1; held_port = win; last = win; accepted++;
        if (win) begin q1.push_back(aluRef(op1, a1, b1)); pend1 = 0; end
        else     begin q0.push_back(aluRef(op0, a0, b0)); pend0 = 0; end
      end
      nextCycle();
      cycles++;
    end
    checkOutput("rand_finished_in_budget", cycles < 20000, 1);
    checkOutput("rand_accepted", accepted, 1000);
    checkOutput("rand_q0_drained", q0.size(), 0);
    checkOutput("rand_q1_drained", q1.size(), 0);
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int g;
    int pg;
    doReset();

    // reset state
    @(negedge clk);
    checkOutput("reset_rsp0_valid", rsp0_valid, 0);
    checkOutput("reset_rsp1_valid", rsp1_valid, 0);
    checkOutput("reset_rsp_data", rsp_data, 0);
    checkOutput("reset_rsp_err", rsp_err, 0);
    checkOutput("reset_req0_ready", req0_ready, 0);
    checkOutput("reset_req1_ready", req1_ready, 0);
    nextCycle();

    // single port ADD
    applyStimulus(1, OP_ADD, 16, 11, 0, OP_ADD, 0, 0, 1, 1);
    @(negedge clk);
    checkOutput("single_req0_ready", req0_ready, 1);
    checkOutput("single_req1_ready", req1_ready, 0);
    checkOutput("single_rsp0_early", rsp0_valid, 0);
    nextCycle();
    applyStimulus(0, OP_ADD, 0, 0, 0, OP_ADD, 0, 0, 1, 1);
    @(negedge clk);
    checkOutput("single_rsp0_valid", rsp0_valid, 1);
    checkOutput("single_rsp1_valid", rsp1_valid, 0);
    checkOutput("single_rsp_data", rsp_data, 27);
    checkOutput("single_rsp_err", rsp_err, 0);
    nextCycle();
    @(negedge clk);
    checkOutput("single_rsp0_drained", rsp0_valid, 0);
    nextCycle();

    // contention
    doReset();
    applyStimulus(1, OP_SUB, 17, 10, 1, OP_SRA, 32'h8000_0000, 4, 1, 1);
    for (int i = 0; i <= 4; i++) begin
      @(negedge clk);
      if (i < 4) begin
        g = RR_EN ? (i % 2) : 0;
        checkOutput($sformatf("cont_req0_ready_%0d", i), req0_ready, g == 0);
        checkOutput($sformatf("cont_req1_ready_%0d", i), req1_ready, g == 1);
      end
      if (i > 0) begin
        pg = RR_EN ? ((i - 1) % 2) : 0;
        checkOutput($sformatf("cont_rsp0_valid_%0d", i), rsp0_valid, pg == 0);
        checkOutput($sformatf("cont_rsp1_valid_%0d", i), rsp1_valid, pg == 1);
        checkOutput($sformatf("cont_rsp_data_%0d", i), rsp_data, (pg == 1) ? 32'hF800_0000 : 32'd7);
      end
      nextCycle();
      if (i == 3) applyStimulus(0, OP_ADD, 0, 0, 0, OP_ADD, 0, 0, 1, 1);
    end

    // backpressure
    doReset();
    applyStimulus(0, OP_ADD, 0, 0, 1, OP_PASS_B, 32'h1234, 192, 0, 0);
    @(negedge clk);
    checkOutput("bp_req1_ready", req1_ready, 1);
    nextCycle();
    applyStimulus(1, OP_ADD, 1, 2, 0, OP_ADD, 0, 0, 1, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput($sformatf("bp_rsp1_valid_%0d", i), rsp1_valid, 1);
      checkOutput($sformatf("bp_rsp_data_%0d", i), rsp_data, 192);
      checkOutput($sformatf("bp_req0_ready_%0d", i), req0_ready, 0);
      checkOutput($sformatf("bp_req1_ready_%0d", i), req1_ready, 0);
      nextCycle();
    end
    rsp1_ready = 1'b1;
    @(negedge clk);
    checkOutput("bp_req0_ready_release", req0_ready, 1);
    nextCycle();
    applyStimulus(0, OP_ADD, 0, 0, 0, OP_ADD, 0, 0, 1, 1);
    @(negedge clk);
    checkOutput("bp_rsp0_valid", rsp0_valid, 1);
    checkOutput("bp_rsp1_valid", rsp1_valid, 0);
    checkOutput("bp_rsp_data", rsp_data, 3);
    nextCycle();

    // illegal op
    doReset();
    applyStimulus(1, 4'b1010, 5, 3, 0, OP_ADD, 0, 0, 1, 1);
    nextCycle();
    applyStimulus(0, OP_ADD, 0, 0, 0, OP_ADD, 0, 0, 1, 1);
    @(negedge clk);
    checkOutput("illegal_rsp0_valid", rsp0_valid, 1);
    checkOutput("illegal_rsp_err", rsp_err, 1);
    checkOutput("illegal_rsp_data", rsp_data, 0);
    nextCycle();

    // reset while a result is held
    doReset();
    applyStimulus(1, OP_ADD, 40, 2, 0, OP_ADD, 0, 0, 0, 0);
    nextCycle();
    applyStimulus(0, OP_ADD, 0, 0, 0, OP_ADD, 0, 0, 0, 0);
    @(negedge clk);
    checkOutput("rst_held_rsp0_valid", rsp0_valid, 1);
    checkOutput("rst_held_rsp_data", rsp_data, 42);
    rst_n = 1'b0;
    #1;
    checkOutput("rst_async_rsp0_valid", rsp0_valid, 0);
    checkOutput("rst_async_rsp1_valid", rsp1_valid, 0);
    checkOutput("rst_async_rsp_data", rsp_data, 0);
    checkOutput("rst_async_rsp_err", rsp_err, 0);
    checkOutput("rst_async_req0_ready", req0_ready, 0);
    checkOutput("rst_async_req1_ready", req1_ready, 0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    nextCycle();
    applyStimulus(1, OP_ADD, 2, 2, 1, OP_ADD, 3, 3, 1, 1);
    @(negedge clk);
    checkOutput("rst_first_req0_ready", req0_ready, 1);
    checkOutput("rst_first_req1_ready", req1_ready, 0);
    nextCycle();
    applyStimulus(0, OP_ADD, 0, 0, 0, OP_ADD, 0, 0, 1, 1);
    @(negedge clk);
    checkOutput("rst_first_rsp0_valid", rsp0_valid, 1);
    checkOutput("rst_first_rsp_data", rsp_data, 4);
    nextCycle();

    // randomized scoreboard run
    doReset();
    runRandom();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
